// File: rtl/fetch_pkg.sv
// Shared widths, opcode constants and state encoding for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned OPC_W  = 5;
    localparam int unsigned OPND_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [OPC_W-1:0] JMP_OPC = 5'b01001;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // True when the word is an unconditional jump back to the address it was fetched from.
    function automatic logic is_self_jump(
        input logic [OPC_W-1:0]  opc,
        input logic [OPND_W-1:0] opnd,
        input logic [ADDR_W-1:0] pc,
        input logic [OPC_W-1:0]  jmp_opc
    );
        return (opc == jmp_opc) && (opnd == pc);
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: redirect on jump, otherwise increment (16-bit wrap) when a word is loaded.
module fetch_pc #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_jmp,
    input  logic [15:0] i_jmp_addr,
    input  logic        i_inc,
    output logic [15:0] o_pc
);
    import fetch_pkg::*;

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_ADDR;
        end else if (i_jmp) begin
            r_pc <= i_jmp_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, latches ROM words into the IR and hands them to the
// decoder over valid/ready, with jump redirect, halt/resume and self-loop halt detection.
module instr_fetch #(
    parameter int unsigned ROM_WIDTH  = 21,
    parameter logic [15:0] RESET_ADDR = 16'h0000,
    parameter logic [4:0]  JMP_OPC    = 5'b01001,
    parameter bit          SELF_HALT  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [15:0]          o_rom_addr,
    input  logic [ROM_WIDTH-1:0] i_rom_data,
    output logic [ROM_WIDTH-1:0] o_ir,
    output logic [15:0]          o_ir_pc,
    output logic                 o_ir_valid,
    input  logic                 i_ir_ready,
    input  logic                 i_jmp_valid,
    input  logic [15:0]          i_jmp_addr,
    input  logic                 i_halt_req,
    input  logic                 i_resume,
    output logic                 o_halted,
    output logic [15:0]          o_fetch_cnt
);
    import fetch_pkg::*;

    state_e                r_state;
    state_e                w_state_d;
    logic [ROM_WIDTH-1:0]  r_ir;
    logic [ADDR_W-1:0]     r_ir_pc;
    logic                  r_ir_valid;
    logic                  r_halted;
    logic [15:0]           r_fetch_cnt;
    logic [ADDR_W-1:0]     w_pc;
    logic                  w_deliver;
    logic                  w_self_halt;
    logic                  w_load;

    assign w_deliver   = r_ir_valid & i_ir_ready;
    assign w_self_halt = SELF_HALT && w_deliver &&
                         is_self_jump(r_ir[ROM_WIDTH-1 -: OPC_W], r_ir[OPND_W-1:0], r_ir_pc,
                                      JMP_OPC);
    // A self-loop delivery suppresses the parallel load so the PC stays put for resume.
    assign w_load = (r_state != HALT) & ~i_jmp_valid & ~w_self_halt &
                    (~r_ir_valid | i_ir_ready);

    fetch_pc #(
        .RESET_ADDR (RESET_ADDR)
    ) u_fetch_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_jmp      (i_jmp_valid),
        .i_jmp_addr (i_jmp_addr),
        .i_inc      (w_load),
        .o_pc       (w_pc)
    );

    always_comb begin
        w_state_d = r_state;
        if (i_jmp_valid) begin
            w_state_d = FILL;
        end else if (w_self_halt) begin
            w_state_d = HALT;
        end else begin
            unique case (r_state)
                FILL, RUN: begin
                    if (i_halt_req) begin
                        w_state_d = HALT;
                    end else if (w_load) begin
                        w_state_d = RUN;
                    end
                end
                HALT: begin
                    if (i_resume && !i_halt_req) begin
                        w_state_d = RUN;
                    end
                end
                default: w_state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_halted    <= 1'b0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_cnt <= '0;
        end else begin
            r_state  <= w_state_d;
            r_halted <= (w_state_d == HALT);
            if (w_deliver && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (i_jmp_valid) begin
                r_ir_valid <= 1'b0;
            end else if (w_load) begin
                r_ir       <= i_rom_data;
                r_ir_pc    <= w_pc;
                r_ir_valid <= 1'b1;
            end else if (w_deliver) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    assign o_rom_addr  = w_pc;
    assign o_ir        = r_ir;
    assign o_ir_pc     = r_ir_pc;
    assign o_ir_valid  = r_ir_valid;
    assign o_halted    = r_halted;
    assign o_fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a
// behavioural model of the fetch stream.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [20:0] rom_data;
    logic [20:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [15:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_ir        (ir),
        .o_ir_pc     (ir_pc),
        .o_ir_valid  (ir_valid),
        .i_ir_ready  (ir_ready),
        .i_jmp_valid (jmp_valid),
        .i_jmp_addr  (jmp_addr),
        .i_halt_req  (halt_req),
        .i_resume    (resume),
        .o_halted    (halted),
        .o_fetch_cnt (fetch_cnt)
    );

    // ROM image: word k = {11101, k}, except a jump-to-self planted at 0x0010.
    function automatic logic [20:0] rom_word(input logic [15:0] a);
        if (a == 16'h0010) return 21'b010010000000000010000;
        return {5'b11101, a};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: next address, the word held for the decoder, halt flag, delivery count.
    logic [15:0] m_pc;
    logic [20:0] m_ir;
    logic [15:0] m_ir_pc;
    bit          m_valid;
    bit          m_halt;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 16'h0000; m_ir = '0; m_ir_pc = '0; m_valid = 0; m_halt = 0; m_cnt = 0;
        end else begin
            bit delivered, loop_home, can_fetch;
            delivered = m_valid && ir_ready;
            loop_home = delivered && (m_ir[20:16] == 5'b01001) && (m_ir[15:0] == m_ir_pc);
            if (delivered && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (jmp_valid) begin
                m_pc = jmp_addr; m_valid = 0; m_halt = 0;
            end else begin
                can_fetch = !m_halt && !loop_home && (!m_valid || ready_ok());
                if (loop_home) m_halt = 1;
                else if (m_halt) m_halt = !(resume && !halt_req);
                else m_halt = halt_req;
                if (can_fetch) begin
                    m_ir = rom_word(m_pc); m_ir_pc = m_pc; m_valid = 1; m_pc = m_pc + 16'd1;
                end else if (delivered) begin
                    m_valid = 0;
                end
            end
        end
    end

    function automatic bit ready_ok();
        return ir_ready;
    endfunction

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("rom_addr", {16'h0, rom_addr}, {16'h0, m_pc});
            check("ir_valid", {31'h0, ir_valid}, {31'h0, m_valid});
            check("halted", {31'h0, halted}, {31'h0, m_halt});
            check("fetch_cnt", {16'h0, fetch_cnt}, m_cnt);
            if (m_valid) begin
                check("ir", {11'h0, ir}, {11'h0, m_ir});
                check("ir_pc", {16'h0, ir_pc}, {16'h0, m_ir_pc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] held_cnt;
        int r;
        rst_n = 1'b0; ir_ready = 1'b1; jmp_valid = 1'b0; jmp_addr = '0;
        halt_req = 1'b0; resume = 1'b0;
        #12;
        rst_n = 1'b1;
        cmp_en = 1;
        check("rst ir_valid", {31'h0, ir_valid}, 32'd0);
        check("rst rom_addr", {16'h0, rom_addr}, 32'd0);
        check("rst fetch_cnt", {16'h0, fetch_cnt}, 32'd0);
        check("rst halted", {31'h0, halted}, 32'd0);

        tick();
        check("first ir_valid", {31'h0, ir_valid}, 32'd1);
        check("first ir", {11'h0, ir}, 32'h1D0000);
        repeat (4) tick();
        check("stream ir_pc", {16'h0, ir_pc}, 32'd4);
        check("stream cnt", {16'h0, fetch_cnt}, 32'd4);

        ir_ready = 1'b0;
        repeat (3) tick();
        check("stall ir_pc", {16'h0, ir_pc}, 32'd4);
        check("stall pc", {16'h0, rom_addr}, 32'd5);
        check("stall cnt", {16'h0, fetch_cnt}, 32'd4);
        ir_ready = 1'b1;
        tick();
        check("release ir_pc", {16'h0, ir_pc}, 32'd5);
        check("release cnt", {16'h0, fetch_cnt}, 32'd5);

        jmp_valid = 1'b1; jmp_addr = 16'h0010;
        tick();
        jmp_valid = 1'b0;
        check("jmp flush", {31'h0, ir_valid}, 32'd0);
        check("jmp cnt", {16'h0, fetch_cnt}, 32'd6);
        tick();
        check("jmp target pc", {16'h0, ir_pc}, 32'h10);
        check("jmp target ir", {11'h0, ir}, 32'h090010);
        tick();
        check("self halt", {31'h0, halted}, 32'd1);
        check("self halt cnt", {16'h0, fetch_cnt}, 32'd7);
        repeat (2) tick();
        check("self halt hold cnt", {16'h0, fetch_cnt}, 32'd7);
        check("self halt pc", {16'h0, rom_addr}, 32'h11);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume halted", {31'h0, halted}, 32'd0);
        tick();
        check("resume ir_pc", {16'h0, ir_pc}, 32'h11);

        jmp_valid = 1'b1; jmp_addr = 16'hFFFF;
        tick();
        jmp_valid = 1'b0;
        tick();
        check("wrap ffff", {16'h0, ir_pc}, 32'hFFFF);
        tick();
        check("wrap 0000", {16'h0, ir_pc}, 32'h0000);

        halt_req = 1'b1;
        tick();
        check("halt pending valid", {31'h0, ir_valid}, 32'd1);
        check("halt flag", {31'h0, halted}, 32'd1);
        tick();
        check("halt drained", {31'h0, ir_valid}, 32'd0);
        held_cnt = fetch_cnt;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume ignored", {31'h0, halted}, 32'd1);
        check("halt cnt hold", {16'h0, fetch_cnt}, {16'h0, held_cnt});
        halt_req = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        check("halt resume ir_pc", {16'h0, ir_pc}, 32'd2);

        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async ir_valid", {31'h0, ir_valid}, 32'd0);
        check("async ir", {11'h0, ir}, 32'd0);
        check("async ir_pc", {16'h0, ir_pc}, 32'd0);
        check("async rom_addr", {16'h0, rom_addr}, 32'd0);
        check("async cnt", {16'h0, fetch_cnt}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check("restart ir_pc", {16'h0, ir_pc}, 32'd0);
        check("restart valid", {31'h0, ir_valid}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            ir_ready  = ($urandom_range(0, 3) != 0);
            jmp_valid = ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 3);
            jmp_addr  = (r == 0) ? 16'h000E : (r == 1) ? 16'hFFFE : 16'($urandom);
            if ($urandom_range(0, 99) < 3) halt_req = ~halt_req;
            resume    = ($urandom_range(0, 9) == 0);
            tick();
        end

        ir_ready = 1'b1; jmp_valid = 1'b0; halt_req = 1'b0; resume = 1'b1;
        for (int i = 0; i < 70000 && fetch_cnt != 16'hFFFF; i++) tick();
        repeat (5) tick();
        check("cnt saturate", {16'h0, fetch_cnt}, 32'hFFFF);

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
